systolic_mac_pe: RTL
====================

// Module: systolic_mac_pe
// PURPOSE
//  Parametrised systolic-array processing element for the matrix-multiply fabric.
//  Forwards A (row) and B (column) operands to its neighbours with a valid qualifier.
//  Accumulates one dot product per job, delimited by first/last markers.
//  Unloads finished results through a per-column shift chain, so the PE can start the next tile.
// PARAMETERS
//  DATA_W    16  operand width (a_in, b_in)
//  ACC_W     40  accumulator/result width; must be >= 2*DATA_W
//  SIGNED    1   1: two's-complement operands and product; 0: unsigned
//  SATURATE  1   1: clamp accumulator on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       synchronous, active-high
//  in_valid       in   1       a_in/b_in/first_in/last_in qualify this cycle
//  a_in           in   DATA_W  A operand from west neighbour
//  b_in           in   DATA_W  B operand from north neighbour
//  first_in       in   1       beat is first term of a new dot product
//  last_in        in   1       beat is final term of the dot product
//  a_out          out  DATA_W  registered A to east neighbour
//  b_out          out  DATA_W  registered B to south neighbour
//  out_valid      out  1       registered in_valid
//  first_out      out  1       registered first_in
//  last_out       out  1       registered last_in
//  drain_load     in   1       load own finished result into the drain chain
//  drain_shift    in   1       shift the drain chain by one PE
//  res_in         in   ACC_W   drain chain input from upstream PE (tie 0 at chain head)
//  res_in_valid   in   1       valid for res_in
//  res_in_ovf     in   1       overflow flag accompanying res_in
//  res_out        out  ACC_W   drain chain output
//  res_out_valid  out  1       res_out holds a result
//  res_out_ovf    out  1       overflow/saturation occurred in the res_out dot product
//  done           out  1       finished result held, awaiting drain_load
//  err            out  1       sticky protocol error
// BEHAVIOUR
//  - Reset: all outputs 0, accumulator 0, ovf tracker 0, state IDLE.
//  - Forwarding, every cycle regardless of state:
//    - out_valid/first_out/last_out <= inputs, one cycle of latency.
//    - a_out/b_out load a_in/b_in only when in_valid=1; otherwise they hold.
//  - Product p = a_in*b_in, 2*DATA_W bits, sign- or zero-extended to ACC_W per SIGNED.
//  - Accumulate, ACCUM state only: s = acc + p.
//    - Overflow test: signed = operand signs equal and sum sign differs; unsigned = carry out.
//    - Overflow with SATURATE=1: acc <= max or min representable value (unsigned: all ones).
//    - Overflow with SATURATE=0: acc <= s (wrapped).
//    - Either way, ovf tracker is set sticky.
//  - FSM states: IDLE, ACCUM, DONE.
//    - IDLE
//      - in_valid & first_in: acc <= p; ovf <= 0.
//        - Next state ACCUM, or DONE if last_in is also 1.
//      - in_valid & !first_in: beat ignored, err <= 1.
//    - ACCUM
//      - in_valid: accumulate. If last_in, next state DONE.
//      - in_valid & first_in (restart without last): err <= 1; acc <= p; ovf <= 0; remain ACCUM.
//    - DONE
//      - done = 1 (registered, asserted the cycle after the last beat).
//      - acc holds its value.
//      - in_valid without a same-cycle drain_load: beat ignored, err <= 1.
//  - Drain chain, evaluated every cycle; drain_load has priority over drain_shift:
//    - drain_load in DONE:
//      - res_out <= acc, res_out_ovf <= ovf, res_out_valid <= 1.
//      - Next state IDLE.
//      - A same-cycle in_valid & first_in is accepted as in IDLE (acc <= p, next ACCUM/DONE).
//    - drain_load outside DONE: no load, err <= 1; a drain_shift in the same cycle still applies.
//    - drain_shift (no load): res_out/res_out_valid/res_out_ovf <= res_in/res_in_valid/res_in_ovf.
//    - Neither asserted: drain registers hold.
//  - err is cleared only by reset.
//  - Reset asserted mid-job or mid-drain: everything returns to reset values the next edge.
// TESTING
//  - Unsigned 4-term dot product, SIGNED=0, DATA_W=16:
//    - Stimulus: a={1,2,3,4}, b={5,6,7,8}, first on beat 0, last on beat 3, drain_load.
//    - Required: res_out=70, res_out_valid=1, res_out_ovf=0; done rises 1 cycle after beat 3.
//  - Signed, SIGNED=1:
//    - Stimulus: a={-3,7}, b={4,-2}.
//    - Required: res_out=-26 (ACC_W two's complement); a_out/b_out echo each beat 1 cycle later.
//  - Saturation, ACC_W=32, DATA_W=16, SIGNED=1, SATURATE=1:
//    - Stimulus: 3 beats of 32767*32767.
//    - Required: res_out=0x7FFFFFFF, res_out_ovf=1.
//    - Same stimulus with SATURATE=0: wrapped sum, res_out_ovf=1.
//  - 3-PE drain chain:
//    - Stimulus: results 10/20/30; drain_load on all three, then 2 drain_shift cycles.
//    - Required: tail res_out sequence 30, 20, 10, each with res_out_valid=1.
//  - Back-to-back jobs:
//    - Stimulus: drain_load coincident with in_valid & first_in (a=2, b=3) in DONE.
//    - Required: old result drained; new acc=6; state ACCUM; err=0.
//  - Protocol and reset:
//    - Stimulus: in_valid in DONE without drain_load.
//      - Required: err=1, acc unchanged.
//    - Stimulus: reset during ACCUM.
//      - Required: all outputs 0 next cycle.

Source files
------------

// File: rtl/systolic_mac_pe.sv
// Systolic-array processing element: forwards A/B operands east/south, accumulates one
// dot product per job (first/last delimited) and unloads results through a drain chain.
module systolic_mac_pe #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ACC_W    = 40,
   parameter bit          SIGNED   = 1'b1,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              first_in,
   input  logic              last_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              out_valid,
   output logic              first_out,
   output logic              last_out,
   input  logic              drain_load,
   input  logic              drain_shift,
   input  logic [ACC_W-1:0]  res_in,
   input  logic              res_in_valid,
   input  logic              res_in_ovf,
   output logic [ACC_W-1:0]  res_out,
   output logic              res_out_valid,
   output logic              res_out_ovf,
   output logic              done,
   output logic              err
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] a_out_q, a_out_d;
   logic [DATA_W-1:0] b_out_q, b_out_d;
   logic              out_valid_q, out_valid_d;
   logic              first_out_q, first_out_d;
   logic              last_out_q, last_out_d;
   logic [ACC_W-1:0]  res_q, res_d;
   logic              res_valid_q, res_valid_d;
   logic              res_ovf_q, res_ovf_d;

   logic [PROD_W-1:0] a_x, b_x, prod;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W:0]    sum_x;
   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  acc_add;
   logic              add_ovf;
   logic              load_ok;

   // Full-precision product, extended to accumulator width according to signedness
   always_comb begin
      if (SIGNED) begin
         a_x = PROD_W'($signed(a_in));
         b_x = PROD_W'($signed(b_in));
      end else begin
         a_x = PROD_W'(a_in);
         b_x = PROD_W'(b_in);
      end
      prod = a_x * b_x;
      if (SIGNED) prod_ext = ACC_W'($signed(prod));
      else        prod_ext = ACC_W'(prod);
   end

   // Accumulator adder with overflow detection and optional clamping
   always_comb begin
      sum_x = {1'b0, acc_q} + {1'b0, prod_ext};
      sum   = sum_x[ACC_W-1:0];
      if (SIGNED) add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                            (sum[ACC_W-1] != acc_q[ACC_W-1]);
      else        add_ovf = sum_x[ACC_W];
      acc_add = sum;
      if (add_ovf && SATURATE) begin
         if (!SIGNED)             acc_add = '1;
         else if (acc_q[ACC_W-1]) acc_add = {1'b1, {(ACC_W-1){1'b0}}};
         else                     acc_add = {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   // Operand/marker forwarding to neighbours; operands hold when no beat is present
   always_comb begin
      out_valid_d = in_valid;
      first_out_d = first_in;
      last_out_d  = last_in;
      a_out_d     = in_valid ? a_in : a_out_q;
      b_out_d     = in_valid ? b_in : b_out_q;
   end

   // Job FSM, accumulator update and drain chain; a load in DONE frees the PE this cycle
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      res_ovf_d   = res_ovf_q;
      load_ok     = drain_load && (state_q == S_DONE);

      if (drain_load && !load_ok) err_d = 1'b1;

      if (load_ok) begin
         res_d       = acc_q;
         res_valid_d = 1'b1;
         res_ovf_d   = ovf_q;
         state_d     = S_IDLE;
      end else if (drain_shift) begin
         res_d       = res_in;
         res_valid_d = res_in_valid;
         res_ovf_d   = res_in_ovf;
      end

      case (load_ok ? S_IDLE : state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (first_in) begin
                  acc_d   = prod_ext;
                  ovf_d   = 1'b0;
                  state_d = last_in ? S_DONE : S_ACCUM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               if (first_in) begin
                  err_d = 1'b1;
                  acc_d = prod_ext;
                  ovf_d = 1'b0;
               end else begin
                  acc_d = acc_add;
                  if (add_ovf) ovf_d = 1'b1;
               end
               if (last_in) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (in_valid) err_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      done_d = (state_d == S_DONE);
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         a_out_q     <= '0;
         b_out_q     <= '0;
         out_valid_q <= 1'b0;
         first_out_q <= 1'b0;
         last_out_q  <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         done_q      <= done_d;
         a_out_q     <= a_out_d;
         b_out_q     <= b_out_d;
         out_valid_q <= out_valid_d;
         first_out_q <= first_out_d;
         last_out_q  <= last_out_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

   assign a_out         = a_out_q;
   assign b_out         = b_out_q;
   assign out_valid     = out_valid_q;
   assign first_out     = first_out_q;
   assign last_out      = last_out_q;
   assign res_out       = res_q;
   assign res_out_valid = res_valid_q;
   assign res_out_ovf   = res_ovf_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule
